// File: rtl/regfile_wb_arb.sv
// ============================================================================
//  Module   : regfile_wb_arb
//  Purpose  : Regfile write-port master. Merges ALU results with FIFO-buffered
//             load results and keeps a per-register busy scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wb_arb #(
    parameter int WIDTH        = 32,
    parameter int RSELWIDTH    = 4,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [RSELWIDTH-1:0]      alu_sel,
    input  logic [WIDTH-1:0]          alu_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [RSELWIDTH-1:0]      mem_sel,
    input  logic [WIDTH-1:0]          mem_data,
    input  logic                      claim_en,
    input  logic [RSELWIDTH-1:0]      claim_sel,
    output logic [2**RSELWIDTH-1:0]   busy,
    output logic                      claim_err,
    output logic                      rf_we,
    output logic [RSELWIDTH-1:0]      rf_wsel,
    output logic [WIDTH-1:0]          rf_wdata
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int SW   = $clog2(STARVE_LIMIT + 1);
    localparam int NREG = 2**RSELWIDTH;
    localparam int EW   = RSELWIDTH + WIDTH;

    logic [EW-1:0]         fifo_mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
    logic [NREG-1:0]       busy_q, busy_d;
    logic                  claim_err_q, claim_err_d;
    logic                  rf_we_q, rf_we_d;
    logic [RSELWIDTH-1:0]  rf_wsel_q, rf_wsel_d;
    logic [WIDTH-1:0]      rf_wdata_q, rf_wdata_d;

    logic                  fifo_empty, fifo_full, starve;
    logic                  alu_win, fifo_win, enq;
    logic [EW-1:0]         fifo_head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_head  = fifo_mem_q[rd_ptr_q];

    // ALU has priority until it has won STARVE_LIMIT times in a row over a waiting load
    assign starve    = !fifo_empty && (starve_cnt_q == SW'(STARVE_LIMIT));
    assign alu_ready = !starve;
    assign mem_ready = !fifo_full;
    assign alu_win   = alu_valid && !starve;
    assign fifo_win  = !alu_win && !fifo_empty;
    assign enq       = mem_valid && !fifo_full;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        starve_cnt_d = starve_cnt_q;
        rf_we_d      = alu_win || fifo_win;
        rf_wsel_d    = rf_wsel_q;
        rf_wdata_d   = rf_wdata_q;

        if (enq)      wr_ptr_d = wr_ptr_q + PW'(1);
        if (fifo_win) rd_ptr_d = rd_ptr_q + PW'(1);
        if (enq && !fifo_win)      count_d = count_q + CW'(1);
        else if (!enq && fifo_win) count_d = count_q - CW'(1);

        if (fifo_empty || fifo_win) starve_cnt_d = '0;
        else if (alu_win)           starve_cnt_d = starve_cnt_q + SW'(1);

        if (alu_win) begin
            rf_wsel_d  = alu_sel;
            rf_wdata_d = alu_data;
        end else if (fifo_win) begin
            rf_wsel_d  = fifo_head[EW-1:WIDTH];
            rf_wdata_d = fifo_head[WIDTH-1:0];
        end
    end

    // Commit clears first so a same-edge claim re-marks the register for the new producer
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q)  busy_d[rf_wsel_q] = 1'b0;
        if (claim_en) busy_d[claim_sel] = 1'b1;
        claim_err_d = claim_en && busy_q[claim_sel] &&
                      !(rf_we_q && (rf_wsel_q == claim_sel));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
            busy_q       <= '0;
            claim_err_q  <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_wsel_q    <= '0;
            rf_wdata_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
            busy_q       <= busy_d;
            claim_err_q  <= claim_err_d;
            rf_we_q      <= rf_we_d;
            rf_wsel_q    <= rf_wsel_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (enq) fifo_mem_q[wr_ptr_q] <= {mem_sel, mem_data};
    end

    assign busy      = busy_q;
    assign claim_err = claim_err_q;
    assign rf_we     = rf_we_q;
    assign rf_wsel   = rf_wsel_q;
    assign rf_wdata  = rf_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arb.sv
// ============================================================================
//  Module   : tb_regfile_wb_arb
//  Purpose  : Directed scoreboard bench for regfile_wb_arb.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arb;

    localparam int WIDTH = 32;
    localparam int RSW   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             alu_valid, mem_valid, claim_en;
    logic [RSW-1:0]   alu_sel, mem_sel, claim_sel;
    logic [WIDTH-1:0] alu_data, mem_data;
    logic             alu_ready, mem_ready, claim_err, rf_we;
    logic [15:0]      busy;
    logic [RSW-1:0]   rf_wsel;
    logic [WIDTH-1:0] rf_wdata;

    int checks   = 0;
    int failures = 0;
    logic [RSW+WIDTH-1:0] exp_q[$];

    regfile_wb_arb #(.WIDTH(WIDTH), .RSELWIDTH(RSW), .DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_sel(alu_sel), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_sel(mem_sel), .mem_data(mem_data),
        .claim_en(claim_en), .claim_sel(claim_sel), .busy(busy), .claim_err(claim_err),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [RSW-1:0] sel, input logic [WIDTH-1:0] data);
        exp_q.push_back({sel, data});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [RSW-1:0] s, input logic [WIDTH-1:0] d);
        alu_valid = v; alu_sel = s; alu_data = d;
    endtask

    task automatic drive_mem(input logic v, input logic [RSW-1:0] s, input logic [WIDTH-1:0] d);
        mem_valid = v; mem_sel = s; mem_data = d;
    endtask

    task automatic idle_inputs();
        drive_alu(1'b0, '0, '0);
        drive_mem(1'b0, '0, '0);
        claim_en = 1'b0; claim_sel = '0;
    endtask

    // Monitor: every write the DUT commits must match the head of the expected queue
    always @(negedge clk) begin
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {28'd0, rf_wsel, rf_wdata}, 64'd0);
            end else begin
                logic [RSW+WIDTH-1:0] e;
                e = exp_q.pop_front();
                chk("write_sel_data", {28'd0, rf_wsel, rf_wdata}, {28'd0, e});
            end
        end
    end

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog time limit reached");
        summary();
        $finish;
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_wsel", rf_wsel, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_claim_err", claim_err, 0);
        chk("rst_ready", {alu_ready, mem_ready}, 2'b11);
        tick(); tick();
        rst = 1'b0;
        tick();

        // ALU only: one-cycle latency
        push_exp(4'd3, 32'hDEADBEEF);
        drive_alu(1'b1, 4'd3, 32'hDEADBEEF);
        @(negedge clk); chk("t1_alu_ready", alu_ready, 1);
        tick(); idle_inputs();
        @(negedge clk); chk("t1_latency", {rf_we, rf_wsel}, {1'b1, 4'd3});
        tick();
        @(negedge clk); chk("t1_we_drop", rf_we, 0);
        tick();

        // Mem path: write lands two cycles after accept
        push_exp(4'd5, 32'h1234);
        drive_mem(1'b1, 4'd5, 32'h1234);
        @(negedge clk); chk("t2_mem_ready", mem_ready, 1);
        tick(); idle_inputs();
        @(negedge clk); chk("t2_no_bypass", rf_we, 0);
        tick();
        @(negedge clk); chk("t2_latency", {rf_we, rf_wsel}, {1'b1, 4'd5});
        tick();
        @(negedge clk); chk("t2_we_drop", rf_we, 0);
        tick();

        // Starvation: three ALU wins over a waiting load, then the load goes
        push_exp(4'd1, 32'h101); push_exp(4'd2, 32'h102); push_exp(4'd3, 32'h103);
        push_exp(4'd4, 32'h104); push_exp(4'd9, 32'h900); push_exp(4'd5, 32'h105);
        drive_alu(1'b1, 4'd1, 32'h101); drive_mem(1'b1, 4'd9, 32'h900);
        @(negedge clk); chk("t3_setup_ready", alu_ready, 1);
        tick(); drive_mem(1'b0, '0, '0);
        for (int i = 2; i <= 4; i++) begin
            drive_alu(1'b1, RSW'(i), WIDTH'(32'h100 + i));
            @(negedge clk); chk("t3_alu_grant", alu_ready, 1);
            tick();
        end
        drive_alu(1'b1, 4'd5, 32'h105);
        @(negedge clk); chk("t3_starve_block", alu_ready, 0);
        tick();
        @(negedge clk); chk("t3_alu_resume", alu_ready, 1);
        tick(); idle_inputs();
        repeat (3) tick();

        // Full FIFO while ALU saturates the port
        push_exp(4'd0, 32'hB0); push_exp(4'd1, 32'hB1); push_exp(4'd2, 32'hB2);
        push_exp(4'd3, 32'hB3); push_exp(4'd8, 32'hC0); push_exp(4'd4, 32'hB4);
        push_exp(4'd9, 32'hC1); push_exp(4'd10, 32'hC2); push_exp(4'd11, 32'hC3);
        for (int i = 0; i < 4; i++) begin
            drive_alu(1'b1, RSW'(i), WIDTH'(32'hB0 + i));
            drive_mem(1'b1, RSW'(8 + i), WIDTH'(32'hC0 + i));
            @(negedge clk); chk("t4_fill_mem_ready", mem_ready, 1);
            tick();
        end
        drive_mem(1'b0, '0, '0);
        drive_alu(1'b1, 4'd4, 32'hB4);
        @(negedge clk); chk("t4_full", {mem_ready, alu_ready}, 2'b00);
        tick();
        @(negedge clk); chk("t4_resume", {mem_ready, alu_ready}, 2'b11);
        tick(); idle_inputs();
        repeat (6) tick();
        chk("t4_drained", exp_q.size(), 0);

        // Scoreboard
        claim_en = 1'b1; claim_sel = 4'd7;
        @(negedge clk); chk("t5_busy_pre", busy[7], 0);
        tick(); claim_en = 1'b0;
        push_exp(4'd7, 32'h777); drive_alu(1'b1, 4'd7, 32'h777);
        @(negedge clk); chk("t5_busy_set", {busy[7], claim_err}, 2'b10);
        tick(); idle_inputs();
        @(negedge clk); chk("t5_busy_until_commit", {rf_we, busy[7]}, 2'b11);
        tick();
        claim_en = 1'b1; claim_sel = 4'd7;
        @(negedge clk); chk("t5_busy_cleared", busy, 0);
        tick(); claim_en = 1'b0;
        push_exp(4'd7, 32'h778); drive_alu(1'b1, 4'd7, 32'h778);
        @(negedge clk); chk("t5_reclaim", {busy[7], claim_err}, 2'b10);
        tick(); idle_inputs();
        claim_en = 1'b1; claim_sel = 4'd7;
        @(negedge clk); chk("t5_commit_cycle", rf_we, 1);
        tick(); claim_en = 1'b0;
        @(negedge clk); chk("t5_set_wins", {busy[7], claim_err}, 2'b10);
        tick();
        claim_en = 1'b1; claim_sel = 4'd7;
        tick(); claim_en = 1'b0;
        @(negedge clk); chk("t5_claim_err", {busy[7], claim_err}, 2'b11);
        tick();
        @(negedge clk); chk("t5_err_pulse", claim_err, 0);
        tick();

        // Reset mid-operation
        push_exp(4'd12, 32'hE0); push_exp(4'd14, 32'hE2);
        drive_alu(1'b1, 4'd12, 32'hE0); drive_mem(1'b1, 4'd13, 32'hE1);
        claim_en = 1'b1; claim_sel = 4'd2;
        tick();
        drive_alu(1'b1, 4'd14, 32'hE2); drive_mem(1'b1, 4'd15, 32'hE3);
        claim_en = 1'b0;
        tick();
        drive_alu(1'b1, 4'd6, 32'hE4); drive_mem(1'b0, '0, '0);
        @(negedge clk); chk("t6_pre_rst", {rf_we, busy[2], mem_ready}, 3'b111);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_outputs", {rf_we, rf_wsel, rf_wdata, busy, claim_err},
            {1'b0, 4'd0, 32'd0, 16'd0, 1'b0});
        chk("t6_rst_ready", {alu_ready, mem_ready}, 2'b11);
        idle_inputs();
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("t6_no_writes_after", exp_q.size(), 0);

        summary();
        $finish;
    end

endmodule

`default_nettype wire
